// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared constants and helpers for the multi-port register file.
//   - DEF_* localparams: default geometry used by reg_file_mp.
//   - lsb_of / msb_of  : bit positions of lane k in a packed bus
//                        built from lanes of w bits each.
// ---------------------------------------------------------------------------
package reg_file_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_N_RD   = 2;
   localparam int DEF_DEPTH  = 32;

   // Lowest bit of lane k in a packed bus of w-bit lanes.
   function automatic int lsb_of(input int k, input int w);
      return k * w;
   endfunction

   // Highest bit of lane k in a packed bus of w-bit lanes.
   function automatic int msb_of(input int k, input int w);
      return (k * w) + w - 1;
   endfunction

endpackage : reg_file_pkg

// File: rtl/reg_file_mp_rd_mux.sv
// ---------------------------------------------------------------------------
// reg_rd_mux
// Combinational DEPTH:1 read select for one read port. Addresses that do
// not correspond to an implemented register return all zeros.
// Ports:
//   regs  in  DEPTH*WIDTH  flattened register contents, reg i at [i*WIDTH +: WIDTH]
//   addr  in  ADDR_W       register address to select
//   data  out WIDTH        selected register, or zero when addr >= DEPTH
// ---------------------------------------------------------------------------
module reg_rd_mux
   import reg_file_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic [DEPTH*WIDTH-1:0] regs,
   input  logic [ADDR_W-1:0]      addr,
   output logic [WIDTH-1:0]       data
);

   // Explicit zero default covers every unimplemented address.
   always_comb begin
      data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr == ADDR_W'(i)) begin
            data = regs[lsb_of(i, WIDTH) +: WIDTH];
         end
      end
   end

endmodule : reg_rd_mux

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Multi-port register file: one write port, N_RD independent read ports
// with one-cycle registered read latency, optional hardwired-zero r0 and
// optional write-to-read forwarding.
// Ports:
//   clk       in  1            clock, all state changes on rising edge
//   rst_n     in  1            synchronous active-low reset
//   wr_en     in  1            write strobe
//   wr_addr   in  ADDR_W       write address
//   wr_data   in  WIDTH        write data
//   rd_en     in  N_RD         per-port read request
//   rd_addr   in  N_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   out N_RD*WIDTH   packed registered read data, port k at [k*WIDTH +: WIDTH]
//   rd_valid  out N_RD         rd_data of port k is valid this cycle
// ---------------------------------------------------------------------------
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int N_RD     = DEF_N_RD,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [N_RD-1:0]          rd_en,
   input  logic [N_RD*ADDR_W-1:0]   rd_addr,
   output logic [N_RD*WIDTH-1:0]    rd_data,
   output logic [N_RD-1:0]          rd_valid
);

   // DEPTH may equal 2**ADDR_W, so the limit needs one extra bit.
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0]       mem_reg [DEPTH];
   logic [DEPTH*WIDTH-1:0] mem_flat;
   logic                   wr_acc;

   // A write is accepted only to an implemented, writable register.
   // Discarded writes are also excluded from forwarding via wr_acc.
   always_comb begin
      wr_acc = wr_en && ({1'b0, wr_addr} < DEPTH_LIM);
      if ((ZERO_REG != 0) && (wr_addr == '0)) begin
         wr_acc = 1'b0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_reg
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               mem_reg[gi] <= '0;
            end else if (wr_acc && (wr_addr == ADDR_W'(gi))) begin
               mem_reg[gi] <= wr_data;
            end
         end

         assign mem_flat[lsb_of(gi, WIDTH) +: WIDTH] = mem_reg[gi];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Read ports: select, optional forwarding, output register
   // ---------------------------------------------------------------------
   logic [ADDR_W-1:0] rd_addr_lane [N_RD];
   logic [WIDTH-1:0]  mux_data     [N_RD];
   logic [WIDTH-1:0]  rd_next      [N_RD];
   logic [WIDTH-1:0]  rd_data_reg  [N_RD];
   logic [N_RD-1:0]   rd_valid_reg;

   generate
      for (gi = 0; gi < N_RD; gi++) begin : g_port
         assign rd_addr_lane[gi] = rd_addr[lsb_of(gi, ADDR_W) +: ADDR_W];

         reg_rd_mux #(
            .WIDTH  (WIDTH),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
         ) u_rd_mux (
            .regs (mem_flat),
            .addr (rd_addr_lane[gi]),
            .data (mux_data[gi])
         );

         if (BYPASS != 0) begin : g_bypass
            // Same-edge write wins so the port sees the post-write value.
            always_comb begin
               rd_next[gi] = mux_data[gi];
               if (wr_acc && (rd_addr_lane[gi] == wr_addr)) begin
                  rd_next[gi] = wr_data;
               end
            end
         end else begin : g_no_bypass
            // Register array still holds the pre-write value at the edge.
            assign rd_next[gi] = mux_data[gi];
         end

         // rd_data only updates on a read so it holds across idle cycles.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rd_data_reg[gi]  <= '0;
               rd_valid_reg[gi] <= 1'b0;
            end else begin
               rd_valid_reg[gi] <= rd_en[gi];
               if (rd_en[gi]) begin
                  rd_data_reg[gi] <= rd_next[gi];
               end
            end
         end

         assign rd_data[lsb_of(gi, WIDTH) +: WIDTH] = rd_data_reg[gi];
      end
   endgenerate

   assign rd_valid = rd_valid_reg;

endmodule : reg_file_mp
